// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the D-stage branch resolution controller.
// Branch op codes are shared with the branch comparator. State codes are
// fixed so that they read directly in waveforms.
package branch_resolve_ctrl_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned STAT_W = 32;

    typedef enum logic [OP_W-1:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_BLTZ = 3'd5,
        BR_BGEZ = 3'd6,
        BR_RSVD = 3'd7
    } br_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EVAL     = 2'd1,
        ST_REDIRECT = 2'd2
    } br_state_e;

    // Two-register compares also need rt forwarded.
    function automatic logic op_uses_rt(input logic [OP_W-1:0] op);
        return (op == BR_BEQ) || (op == BR_BNE);
    endfunction

    function automatic logic op_valid(input logic [OP_W-1:0] op);
        return (op != BR_NONE) && (op != BR_RSVD);
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Decode / hazard / comparator / fetch signals seen by the branch controller.
//   master : pipeline side (decode, hazard unit, comparator, fetch)
//   slave  : branch_resolve_ctrl
interface branch_resolve_ctrl_if;
    import branch_resolve_ctrl_pkg::*;

    logic              br_valid;
    logic              br_ready;
    logic [OP_W-1:0]   br_op;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] br_pc8;
    logic              rs_ready;
    logic              rt_ready;
    logic              cmp_out;
    logic [OP_W-1:0]   cmp_op;
    logic              flush;
    logic              stall_d;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              timeout;

    modport master (
        output br_valid, br_op, br_target, br_pc8, rs_ready, rt_ready, cmp_out, flush,
        input  br_ready, cmp_op, stall_d, redirect_valid, redirect_pc, timeout
    );

    modport slave (
        input  br_valid, br_op, br_target, br_pc8, rs_ready, rt_ready, cmp_out, flush,
        output br_ready, cmp_op, stall_d, redirect_valid, redirect_pc, timeout
    );

endinterface

// File: rtl/branch_resolve_ctrl_br_wait_counter.sv
// br_wait_counter: counts EVAL cycles spent waiting for operands.
// Ports: clk, reset (async, active-high), clr (sync clear, wins over inc),
//   inc (count one waiting cycle), tc_c (this increment brings the count
//   to MAX_WAIT, i.e. the wait budget is exhausted this cycle).
// The count saturates at MAX_WAIT.
module br_wait_counter #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic tc_c
);

    localparam logic [WAIT_W-1:0] MAX_CNT  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] LAST_CNT = WAIT_W'(MAX_WAIT - 1);

    logic [WAIT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != MAX_CNT)) begin
            cnt_q <= cnt_q + WAIT_W'(1);
        end
    end

    assign tc_c = inc && (cnt_q == LAST_CNT);

endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: sequences the D-stage branch comparator.
// Accepts one branch from decode, stalls F/D until operands are forwarded,
// samples the comparator, then issues a one-cycle PC redirect (target if
// taken, PC+8 if not, since the delay slot is already fetched).
// Ports: clk, reset (async, active-high), bus (branch_resolve_ctrl_if.slave).
// Optional: BR_STATS_EN adds saturating stat_taken / stat_not_taken /
//   stat_timeout counters (timeouts count as not-taken and as timeouts).
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_resolve_ctrl_if.slave  bus
`ifdef BR_STATS_EN
    ,
    output logic [STAT_W-1:0]     stat_taken,
    output logic [STAT_W-1:0]     stat_not_taken,
    output logic [STAT_W-1:0]     stat_timeout
`endif
);

    br_state_e         state_q, state_nxt;
    logic [OP_W-1:0]   op_q, op_nxt;
    logic [ADDR_W-1:0] target_q, target_nxt;
    logic [ADDR_W-1:0] pc8_q, pc8_nxt;
    logic              taken_q, taken_nxt;

    logic              stall_q, stall_nxt;
    logic [OP_W-1:0]   cmp_op_q, cmp_op_nxt;
    logic              redirect_valid_q, redirect_valid_nxt;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_nxt;
    logic              timeout_q, timeout_nxt;

    logic              opnd_ok_c;
    logic              wait_inc_c;
    logic              wait_clr_c;
    logic              wait_tc_c;

    // Invalid ops resolve immediately, so they never spend wait budget.
    assign opnd_ok_c  = bus.rs_ready && (bus.rt_ready || !op_uses_rt(op_q));
    assign wait_inc_c = (state_q == ST_EVAL) && op_valid(op_q) && !opnd_ok_c;
    assign wait_clr_c = bus.flush || (state_q != ST_EVAL);

    br_wait_counter #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait (
        .clk   (clk),
        .reset (reset),
        .clr   (wait_clr_c),
        .inc   (wait_inc_c),
        .tc_c  (wait_tc_c)
    );

    // Next-state and next-output logic; outputs are registered from the next state.
    always_comb begin
        state_nxt   = state_q;
        op_nxt      = op_q;
        target_nxt  = target_q;
        pc8_nxt     = pc8_q;
        taken_nxt   = taken_q;
        timeout_nxt = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.br_valid) begin
                    op_nxt     = bus.br_op;
                    target_nxt = bus.br_target;
                    pc8_nxt    = bus.br_pc8;
                    state_nxt  = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (!op_valid(op_q)) begin
                    taken_nxt = 1'b0;
                    state_nxt = ST_REDIRECT;
                end else if (opnd_ok_c) begin
                    taken_nxt = bus.cmp_out;
                    state_nxt = ST_REDIRECT;
                end else if (wait_tc_c) begin
                    taken_nxt   = 1'b0;
                    timeout_nxt = 1'b1;
                    state_nxt   = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A flush kills whatever is in flight, including a same-cycle accept.
        if (bus.flush) begin
            state_nxt   = ST_IDLE;
            taken_nxt   = 1'b0;
            timeout_nxt = 1'b0;
        end

        stall_nxt          = (state_nxt != ST_IDLE);
        cmp_op_nxt         = (state_nxt == ST_EVAL) ? op_nxt : OP_W'(BR_NONE);
        redirect_valid_nxt = (state_nxt == ST_REDIRECT);
        redirect_pc_nxt    = redirect_valid_nxt ? (taken_nxt ? target_nxt : pc8_nxt) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            op_q             <= '0;
            target_q         <= '0;
            pc8_q            <= '0;
            taken_q          <= 1'b0;
            stall_q          <= 1'b0;
            cmp_op_q         <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            timeout_q        <= 1'b0;
        end else begin
            state_q          <= state_nxt;
            op_q             <= op_nxt;
            target_q         <= target_nxt;
            pc8_q            <= pc8_nxt;
            taken_q          <= taken_nxt;
            stall_q          <= stall_nxt;
            cmp_op_q         <= cmp_op_nxt;
            redirect_valid_q <= redirect_valid_nxt;
            redirect_pc_q    <= redirect_pc_nxt;
            timeout_q        <= timeout_nxt;
        end
    end

    assign bus.br_ready       = (state_q == ST_IDLE);
    assign bus.stall_d        = stall_q;
    assign bus.cmp_op         = cmp_op_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.timeout        = timeout_q;

`ifdef BR_STATS_EN
    // Outcome counters, bumped once per issued redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_taken     <= '0;
            stat_not_taken <= '0;
            stat_timeout   <= '0;
        end else if (redirect_valid_q) begin
            if (taken_q) begin
                if (stat_taken != '1) stat_taken <= stat_taken + STAT_W'(1);
            end else begin
                if (stat_not_taken != '1) stat_not_taken <= stat_not_taken + STAT_W'(1);
            end
            if (timeout_q && (stat_timeout != '1)) begin
                stat_timeout <= stat_timeout + STAT_W'(1);
            end
        end
    end
`endif

endmodule
